// File: rtl/valu_serial.sv
// valu_serial: serial vector ALU, NUM_UNITS lanes per beat, NUM_ELEMS/NUM_UNITS beats per operation.
// Define VALU_SATURATE_EN to clamp ADD/SUB/MUL results on signed overflow instead of wrapping.
module valu_serial #(
    parameter int ELEM_W    = 16,
    parameter int NUM_ELEMS = 16,
    parameter int NUM_UNITS = 4,
    parameter int FRAC_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_ELEMS*ELEM_W-1:0]   a,
    input  logic [NUM_ELEMS*ELEM_W-1:0]   b,
    input  logic [ELEM_W-1:0]             c,
    input  logic [2:0]                    opcode,
    input  logic                          flag_scalar,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_ELEMS*ELEM_W-1:0]   result,
    output logic [NUM_ELEMS*4-1:0]        flags
);
    localparam int BEATS = NUM_ELEMS / NUM_UNITS;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int M     = ELEM_W - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [NUM_ELEMS*ELEM_W-1:0] a_r, b_r;
    logic [ELEM_W-1:0]           c_r;
    logic [2:0]                  op_r;
    logic                        scal_r;
    logic [BW-1:0]               beat;

    // Returns {V, C, N, Z, result} for one element.
    function automatic logic [ELEM_W+3:0] lane(input logic [2:0] op, input logic [ELEM_W-1:0] x,
                                                input logic [ELEM_W-1:0] y, input logic [ELEM_W-1:0] z);
        logic [ELEM_W:0]            ext;
        logic signed [2*ELEM_W-1:0] xs, ys, p;
        logic [ELEM_W-1:0]          r;
        logic                       v, cy;
        ext = '0;
        xs  = {{ELEM_W{x[M]}}, x};
        ys  = {{ELEM_W{y[M]}}, y};
        p   = '0;
        r   = '0;
        v   = 1'b0;
        cy  = 1'b0;
        case (op)
            3'b000: begin
                ext = {1'b0, x} + {1'b0, y};
                r   = ext[M:0];
                cy  = ext[ELEM_W];
                v   = (x[M] == y[M]) && (r[M] != x[M]);
            end
            3'b001: begin
                ext = {1'b0, x} - {1'b0, y};
                r   = ext[M:0];
                cy  = ext[ELEM_W];
                v   = (x[M] != y[M]) && (r[M] != x[M]);
            end
            3'b010: begin
                p = (xs * ys) >>> FRAC_W;
                r = p[M:0];
                v = !(&p[2*ELEM_W-1:M]) && (|p[2*ELEM_W-1:M]);
            end
            3'b011:  r = x & y;
            3'b100:  r = x | y;
            3'b101:  r = x ^ y;
            3'b110:  r = z;
            default: r = '0;
        endcase
`ifdef VALU_SATURATE_EN
        // Overflow direction: MUL follows the full product sign, ADD/SUB follow operand a.
        if (v)
            r = ((op == 3'b010) ? p[2*ELEM_W-1] : x[M]) ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
`endif
        return {v, cy, r[M], r == '0, r};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            beat   <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            state <= state_nx;
            if (in_valid && in_ready) begin
                a_r    <= a;
                b_r    <= b;
                c_r    <= c;
                op_r   <= opcode;
                scal_r <= flag_scalar;
                beat   <= '0;
            end
            if (state == BUSY) begin
                beat <= beat + 1'b1;
                if (scal_r) begin
                    result <= a_r;
                    flags  <= '0;
                    {flags[3:0], result[M:0]} <= lane(op_r, a_r[M:0], b_r[M:0], c_r);
                end else begin
                    for (int u = 0; u < NUM_UNITS; u++)
                        {flags[(int'(beat)*NUM_UNITS+u)*4 +: 4], result[(int'(beat)*NUM_UNITS+u)*ELEM_W +: ELEM_W]} <=
                            lane(op_r, a_r[(int'(beat)*NUM_UNITS+u)*ELEM_W +: ELEM_W],
                                 b_r[(int'(beat)*NUM_UNITS+u)*ELEM_W +: ELEM_W], c_r);
                end
            end
        end
    end

    always_comb begin
        state_nx = state == IDLE ? (in_valid ? BUSY : IDLE) :
                   state == BUSY ? ((scal_r || beat == BW'(BEATS-1)) ? DONE : BUSY) :
                   (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end
endmodule

// File: tb/tb_valu_serial.sv
// tb_valu_serial: directed vectors with hand-computed results for valu_serial (default parameters).
module tb_valu_serial;
    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, flag_scalar, out_valid, out_ready;
    logic [255:0] a, b, result, exp_v;
    logic [15:0]  c;
    logic [2:0]   opcode;
    logic [63:0]  flags;
    int           checks = 0, failures = 0, lat;

    valu_serial dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c(c),
        .opcode(opcode), .flag_scalar(flag_scalar), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one operation and measures cycles from the accepting edge to out_valid.
    task automatic run_op(input logic [2:0] op, input logic [255:0] va, input logic [255:0] vb,
                          input logic [15:0] vc, input logic scal, output int n);
        int w = 0;
        a = va; b = vb; c = vc; opcode = op; flag_scalar = scal; in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            step(1);
            w++;
        end
        step(1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step(1);
            n++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flag_scalar = 1'b0;
        a = '0; b = '0; c = '0; opcode = '0;
        step(3);
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result != '0), 64'd0);
        check("rst_flags", flags, 64'd0);

        run_op(3'b000, {16{16'h0001}}, {16{16'h0002}}, 16'h0, 1'b0, lat);
        check("add_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 16; i++) check("add_elem", 64'(result[i*16 +: 16]), 64'h0003);
        check("add_flags", flags, 64'd0);
        check("done_in_ready", 64'(in_ready), 64'd0);
        release_out();

        exp_v = '0; exp_v[15:0] = 16'h7FFF;
        run_op(3'b000, exp_v, 256'h1, 16'h0, 1'b0, lat);
`ifdef VALU_SATURATE_EN
        check("add_ovf_res", 64'(result[15:0]), 64'h7FFF);
        check("add_ovf_flags", 64'(flags[3:0]), 64'h8);
`else
        check("add_ovf_res", 64'(result[15:0]), 64'h8000);
        check("add_ovf_flags", 64'(flags[3:0]), 64'hA);
`endif
        check("add_zero_flags", 64'(flags[63:4]), 64'h111111111111111);
        release_out();

        a = '0; b = '0;
        a[15:0] = 16'h0180; b[15:0] = 16'h0200;
        a[95:80] = 16'hFF00; b[95:80] = 16'h0200;
        a[111:96] = 16'h4000; b[111:96] = 16'h4000;
        run_op(3'b010, a, b, 16'h0, 1'b0, lat);
        check("mul_res", 64'(result[15:0]), 64'h0300);
        check("mul_flags", 64'(flags[3:0]), 64'h0);
        check("mul_neg_res", 64'(result[95:80]), 64'hFE00);
        check("mul_neg_flags", 64'(flags[23:20]), 64'h2);
`ifdef VALU_SATURATE_EN
        check("mul_ovf_res", 64'(result[111:96]), 64'h7FFF);
        check("mul_ovf_flags", 64'(flags[27:24]), 64'h8);
`else
        check("mul_ovf_res", 64'(result[111:96]), 64'h0000);
        check("mul_ovf_flags", 64'(flags[27:24]), 64'h9);
`endif
        release_out();

        a = '0; b = '0;
        b[15:0] = 16'h0001;
        a[31:16] = 16'h0005; b[31:16] = 16'h0003;
        a[47:32] = 16'h8000; b[47:32] = 16'h0001;
        run_op(3'b001, a, b, 16'h0, 1'b0, lat);
        check("sub_borrow_res", 64'(result[15:0]), 64'hFFFF);
        check("sub_borrow_flags", 64'(flags[3:0]), 64'h6);
        check("sub_pos_res", 64'(result[31:16]), 64'h0002);
        check("sub_pos_flags", 64'(flags[7:4]), 64'h0);
`ifdef VALU_SATURATE_EN
        check("sub_ovf_res", 64'(result[47:32]), 64'h8000);
        check("sub_ovf_flags", 64'(flags[11:8]), 64'hA);
`else
        check("sub_ovf_res", 64'(result[47:32]), 64'h7FFF);
        check("sub_ovf_flags", 64'(flags[11:8]), 64'h8);
`endif
        release_out();

        run_op(3'b011, {16{16'hF0F0}}, {16{16'hFF00}}, 16'h0, 1'b0, lat);
        check("and_res", 64'(result[255:240]), 64'hF000);
        check("and_flags", flags, 64'h2222222222222222);
        release_out();
        run_op(3'b100, {16{16'hF0F0}}, {16{16'hFF00}}, 16'h0, 1'b0, lat);
        check("or_res", 64'(result[127:112]), 64'hFFF0);
        release_out();
        run_op(3'b101, {16{16'hF0F0}}, {16{16'hFF00}}, 16'h0, 1'b0, lat);
        check("xor_res", 64'(result[63:48]), 64'h0FF0);
        check("xor_flags", flags, 64'h0);
        release_out();
        run_op(3'b111, {16{16'h1234}}, {16{16'h5678}}, 16'h9, 1'b0, lat);
        check("rsv_latency", 64'(lat), 64'd4);
        check("rsv_res", 64'(result != '0), 64'd0);
        check("rsv_flags", flags, 64'h1111111111111111);
        release_out();

        run_op(3'b110, {16{16'hAAAA}}, {16{16'h5555}}, 16'h1234, 1'b1, lat);
        exp_v = {{15{16'hAAAA}}, 16'h1234};
        check("set_latency", 64'(lat), 64'd1);
        check("set_vector", 64'(result == exp_v), 64'd1);
        check("set_flags", flags, 64'h0);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            opcode = 3'b000;
            step(1);
            check("stall_result", 64'(result == exp_v), 64'd1);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("exit_in_ready", 64'(in_ready), 64'd0);
        step(1);
        out_ready = 1'b0;
        check("post_out_valid", 64'(out_valid), 64'd0);
        check("post_in_ready", 64'(in_ready), 64'd1);
        check("post_result", 64'(result == exp_v), 64'd1);
        step(6);
        check("no_ghost_op", 64'(out_valid), 64'd0);

        a = {16{16'h0001}}; b = {16{16'h0001}}; opcode = 3'b000; flag_scalar = 1'b0;
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(2);
        check("abort_partial", 64'(result[15:0]), 64'h0002);
        rst = 1'b1;
        step(1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_result", 64'(result != '0), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            step(1);
            lat++;
        end
        check("abort_no_output", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
